// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/funct/ALU encodings and the pipelined control bundle
package ctrl_pkg;

    localparam int ALUOP_W_DEF    = 4;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_JR  = 6'd8;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_NOR = 6'd39;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [ALUOP_W_DEF-1:0] ALU_AND = 4'd0;
    localparam logic [ALUOP_W_DEF-1:0] ALU_OR  = 4'd1;
    localparam logic [ALUOP_W_DEF-1:0] ALU_ADD = 4'd2;
    localparam logic [ALUOP_W_DEF-1:0] ALU_SLL = 4'd3;
    localparam logic [ALUOP_W_DEF-1:0] ALU_SUB = 4'd6;
    localparam logic [ALUOP_W_DEF-1:0] ALU_SLT = 4'd7;
    localparam logic [ALUOP_W_DEF-1:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2} reg_dst_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} mem_to_reg_e;

    typedef struct packed {
        logic [ALUOP_W_DEF-1:0]    alu_op;
        logic                      alu_src;
        logic                      branch;
        reg_dst_e                  reg_dst;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
        mem_to_reg_e               mem_to_reg;
        logic [REG_ADDR_W_DEF-1:0] dest;
        logic                      illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        alu_op: '0, alu_src: 1'b0, branch: 1'b0, reg_dst: RD_RT,
        mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
        mem_to_reg: WB_ALU, dest: '0, illegal: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - ID inputs and staged control outputs of the pipeline controller
interface pipe_ctrl_unit_if #(
    parameter int ALUOP_W    = 4,
    parameter int REG_ADDR_W = 5
);
    logic                  InstrValid;
    logic [5:0]            Opcode;
    logic [5:0]            Function;
    logic [REG_ADDR_W-1:0] Rs;
    logic [REG_ADDR_W-1:0] Rt;
    logic [REG_ADDR_W-1:0] Rd;
    logic                  BranchTaken;
    logic                  Stall;
    logic                  Flush_IFID;
    logic                  ID_Jump;
    logic                  ID_JumpReg;
    logic [ALUOP_W-1:0]    EX_ALUOp;
    logic                  EX_ALUSrc;
    logic                  EX_Branch;
    logic [1:0]            EX_RegDst;
    logic                  MEM_MemRead;
    logic                  MEM_MemWrite;
    logic                  WB_RegWrite;
    logic [1:0]            WB_MemtoReg;
    logic [REG_ADDR_W-1:0] WB_DestReg;
    logic                  WB_Illegal;

    modport master (
        output InstrValid, Opcode, Function, Rs, Rt, Rd, BranchTaken,
        input  Stall, Flush_IFID, ID_Jump, ID_JumpReg, EX_ALUOp, EX_ALUSrc, EX_Branch,
               EX_RegDst, MEM_MemRead, MEM_MemWrite, WB_RegWrite, WB_MemtoReg,
               WB_DestReg, WB_Illegal
    );

    modport slave (
        input  InstrValid, Opcode, Function, Rs, Rt, Rd, BranchTaken,
        output Stall, Flush_IFID, ID_Jump, ID_JumpReg, EX_ALUOp, EX_ALUSrc, EX_Branch,
               EX_RegDst, MEM_MemRead, MEM_MemWrite, WB_RegWrite, WB_MemtoReg,
               WB_DestReg, WB_Illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct decode into a control bundle
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output ctrl_bundle_t ctrl,
    output logic         jump,
    output logic         jump_reg,
    output logic         reads_rt
);

    // Decode table; unknown encodings become a bubble carrying the illegal flag.
    // The destination field stays 0 here and is resolved by the caller.
    always_comb begin
        ctrl     = CTRL_BUBBLE;
        jump     = 1'b0;
        jump_reg = 1'b0;
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = RD_RD;
                ctrl.reg_write = 1'b1;
                reads_rt       = 1'b1;
                case (funct)
                    FN_ADD: ctrl.alu_op = ALU_ADD;
                    FN_AND: ctrl.alu_op = ALU_AND;
                    FN_NOR: ctrl.alu_op = ALU_NOR;
                    FN_SLT: ctrl.alu_op = ALU_SLT;
                    FN_SLL: ctrl.alu_op = ALU_SLL;
                    FN_JR: begin
                        ctrl     = CTRL_BUBBLE;
                        jump_reg = 1'b1;
                        reads_rt = 1'b0;
                    end
                    default: begin
                        ctrl         = CTRL_BUBBLE;
                        ctrl.illegal = 1'b1;
                        reads_rt     = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WB_MEM;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                reads_rt       = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_op    = ALU_AND;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                reads_rt    = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_dst    = RD_RA;
                ctrl.mem_to_reg = WB_PC4;
                ctrl.reg_write  = 1'b1;
                jump            = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - staged control bundle with load-use/JR stalls and branch squash
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W    = ALUOP_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic            Clk,
    input  logic            Reset,
    pipe_ctrl_unit_if.slave bus
);

    ctrl_bundle_t id_ctrl, id_bundle;
    ctrl_bundle_t ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
    logic         id_jump, id_jump_reg, id_reads_rt;
    logic         load_use, jr_hazard, stall;
    logic         jump_ok, jump_reg_ok;

    ctrl_decode u_decode (
        .opcode   (bus.Opcode),
        .funct    (bus.Function),
        .ctrl     (id_ctrl),
        .jump     (id_jump),
        .jump_reg (id_jump_reg),
        .reads_rt (id_reads_rt)
    );

    // Resolve the destination in ID; non-writing instructions carry 0 so they never look like hazard sources.
    always_comb begin
        id_bundle      = id_ctrl;
        id_bundle.dest = '0;
        if (id_ctrl.reg_write) begin
            case (id_ctrl.reg_dst)
                RD_RT:   id_bundle.dest = bus.Rt;
                RD_RD:   id_bundle.dest = bus.Rd;
                RD_RA:   id_bundle.dest = REG_ADDR_W_DEF'(31);
                default: id_bundle.dest = '0;
            endcase
        end
    end

    // Hazard detection; a taken branch overrides any stall since ID is being squashed anyway.
    always_comb begin
        load_use  = ex_q.mem_read && (ex_q.dest != '0) &&
                    ((ex_q.dest == bus.Rs) || (id_reads_rt && (ex_q.dest == bus.Rt)));
        jr_hazard = id_jump_reg &&
                    ((ex_q.reg_write && (ex_q.dest != '0) && (ex_q.dest == bus.Rs)) ||
                     (mem_q.mem_read && (mem_q.dest != '0) && (mem_q.dest == bus.Rs)));
        stall     = HAZARD_EN && bus.InstrValid && !bus.BranchTaken && (load_use || jr_hazard);
        jump_ok     = id_jump     && bus.InstrValid && !bus.BranchTaken;
        jump_reg_ok = id_jump_reg && bus.InstrValid && !bus.BranchTaken;
    end

    // Next-stage values: ID/EX takes a bubble on stall, squash or empty slot; later stages always advance.
    always_comb begin
        ex_d  = (stall || bus.BranchTaken || !bus.InstrValid) ? CTRL_BUBBLE : id_bundle;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    // Stage registers, cleared together by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q  <= CTRL_BUBBLE;
            mem_q <= CTRL_BUBBLE;
            wb_q  <= CTRL_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.Stall        = stall;
    assign bus.ID_Jump      = jump_ok;
    assign bus.ID_JumpReg   = jump_reg_ok;
    assign bus.Flush_IFID   = bus.BranchTaken | ((jump_ok | jump_reg_ok) & ~stall);
    assign bus.EX_ALUOp     = ALUOP_W'(ex_q.alu_op);
    assign bus.EX_ALUSrc    = ex_q.alu_src;
    assign bus.EX_Branch    = ex_q.branch;
    assign bus.EX_RegDst    = ex_q.reg_dst;
    assign bus.MEM_MemRead  = mem_q.mem_read;
    assign bus.MEM_MemWrite = mem_q.mem_write;
    assign bus.WB_RegWrite  = wb_q.reg_write;
    assign bus.WB_MemtoReg  = wb_q.mem_to_reg;
    assign bus.WB_DestReg   = REG_ADDR_W'(wb_q.dest);
    assign bus.WB_Illegal   = wb_q.illegal;

    // Fields that later stages carry but no longer drive anything.
    logic unused_fields;
    assign unused_fields = ^{mem_q.alu_op, mem_q.alu_src, mem_q.branch, mem_q.reg_dst,
                             wb_q.alu_op, wb_q.alu_src, wb_q.branch, wb_q.reg_dst,
                             wb_q.mem_read, wb_q.mem_write};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    pipe_ctrl_unit_if bus ();

    pipe_ctrl_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] alu;
        logic       src;
        logic       br;
        logic [1:0] rdst;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] m2r;
        logic [4:0] dest;
        logic       ill;
    } exp_t;

    localparam exp_t EXP_BUBBLE = '{4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0};

    // Instruction table for the decode sweep: ADD, LW, SW, ADDI, ANDI, BEQ, NOR, SLL
    logic [5:0] t_op [8] = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd12, 6'd4, 6'd0, 6'd0};
    logic [5:0] t_fn [8] = '{6'd32, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd39, 6'd0};
    logic [4:0] t_rs [8] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0};
    logic [4:0] t_rt [8] = '{5'd2, 5'd10, 5'd2, 5'd2, 5'd4, 5'd2, 5'd2, 5'd2};
    logic [4:0] t_rd [8] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd6};
    exp_t t_exp [8] = '{
        '{4'd2,  1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 5'd3,  1'b0},
        '{4'd2,  1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd10, 1'b0},
        '{4'd2,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0,  1'b0},
        '{4'd2,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd2,  1'b0},
        '{4'd0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd4,  1'b0},
        '{4'd6,  1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0,  1'b0},
        '{4'd12, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5,  1'b0},
        '{4'd3,  1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 5'd6,  1'b0}
    };

    function automatic exp_t exp_at(input int i);
        if (i < 0 || i > 7) return EXP_BUBBLE;
        return t_exp[i];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic bt);
        bus.InstrValid  = valid;
        bus.Opcode      = op;
        bus.Function    = fn;
        bus.Rs          = rs;
        bus.Rt          = rt;
        bus.Rd          = rd;
        bus.BranchTaken = bt;
        #2;
    endtask

    task automatic nop();
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        nop();
        step();
        step();
        Reset = 1'b0;
    endtask

    function automatic logic [22:0] all_outs();
        return {bus.Stall, bus.Flush_IFID, bus.ID_Jump, bus.ID_JumpReg, bus.EX_ALUOp,
                bus.EX_ALUSrc, bus.EX_Branch, bus.EX_RegDst, bus.MEM_MemRead, bus.MEM_MemWrite,
                bus.WB_RegWrite, bus.WB_MemtoReg, bus.WB_DestReg, bus.WB_Illegal};
    endfunction

    task automatic test_reset();
        do_reset();
        nop();
        checks++; if (all_outs() !== 23'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
    endtask

    task automatic test_decode();
        exp_t e;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(1'b1, t_op[c], t_fn[c], t_rs[c], t_rt[c], t_rd[c], 1'b0);
            else nop();
            checks++; if (bus.Stall !== 1'b0) begin failures++; $display("FAIL dec_stall c=%0d got=%b exp=0", c, bus.Stall); end
            e = exp_at(c - 1);
            checks++; if (bus.EX_ALUOp !== e.alu) begin failures++; $display("FAIL dec_ex_aluop c=%0d got=%0d exp=%0d", c, bus.EX_ALUOp, e.alu); end
            checks++; if (bus.EX_ALUSrc !== e.src) begin failures++; $display("FAIL dec_ex_alusrc c=%0d got=%b exp=%b", c, bus.EX_ALUSrc, e.src); end
            checks++; if (bus.EX_Branch !== e.br) begin failures++; $display("FAIL dec_ex_branch c=%0d got=%b exp=%b", c, bus.EX_Branch, e.br); end
            checks++; if (bus.EX_RegDst !== e.rdst) begin failures++; $display("FAIL dec_ex_regdst c=%0d got=%0d exp=%0d", c, bus.EX_RegDst, e.rdst); end
            e = exp_at(c - 2);
            checks++; if (bus.MEM_MemRead !== e.mr) begin failures++; $display("FAIL dec_mem_read c=%0d got=%b exp=%b", c, bus.MEM_MemRead, e.mr); end
            checks++; if (bus.MEM_MemWrite !== e.mw) begin failures++; $display("FAIL dec_mem_write c=%0d got=%b exp=%b", c, bus.MEM_MemWrite, e.mw); end
            e = exp_at(c - 3);
            checks++; if (bus.WB_RegWrite !== e.rw) begin failures++; $display("FAIL dec_wb_regwrite c=%0d got=%b exp=%b", c, bus.WB_RegWrite, e.rw); end
            checks++; if (bus.WB_MemtoReg !== e.m2r) begin failures++; $display("FAIL dec_wb_memtoreg c=%0d got=%0d exp=%0d", c, bus.WB_MemtoReg, e.m2r); end
            checks++; if (bus.WB_Illegal !== e.ill) begin failures++; $display("FAIL dec_wb_illegal c=%0d got=%b exp=%b", c, bus.WB_Illegal, e.ill); end
            if (e.rw) begin
                checks++; if (bus.WB_DestReg !== e.dest) begin failures++; $display("FAIL dec_wb_dest c=%0d got=%0d exp=%0d", c, bus.WB_DestReg, e.dest); end
            end
            step();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0);              // LW $8,0($1)
        step();
        drive(1'b1, 6'd0, 6'd32, 5'd8, 5'd1, 5'd9, 1'b0);              // ADD $9,$8,$1
        checks++; if (bus.Stall !== 1'b1) begin failures++; $display("FAIL lu_stall_on got=%b exp=1", bus.Stall); end
        checks++; if (bus.Flush_IFID !== 1'b0) begin failures++; $display("FAIL lu_flush got=%b exp=0", bus.Flush_IFID); end
        step();
        drive(1'b1, 6'd0, 6'd32, 5'd8, 5'd1, 5'd9, 1'b0);              // held in IF/ID
        checks++; if (bus.Stall !== 1'b0) begin failures++; $display("FAIL lu_stall_off got=%b exp=0", bus.Stall); end
        checks++; if ({bus.EX_ALUOp, bus.EX_ALUSrc, bus.EX_RegDst} !== 7'd0) begin failures++; $display("FAIL lu_ex_bubble got=%h exp=0", {bus.EX_ALUOp, bus.EX_ALUSrc, bus.EX_RegDst}); end
        checks++; if (bus.MEM_MemRead !== 1'b1) begin failures++; $display("FAIL lu_mem_lw got=%b exp=1", bus.MEM_MemRead); end
        step();
        nop();
        checks++; if (bus.EX_ALUOp !== 4'd2 || bus.EX_RegDst !== 2'd1) begin failures++; $display("FAIL lu_add_in_ex got=%0d/%0d exp=2/1", bus.EX_ALUOp, bus.EX_RegDst); end
        checks++; if (bus.MEM_MemRead !== 1'b0 || bus.MEM_MemWrite !== 1'b0) begin failures++; $display("FAIL lu_mem_bubble got=%b%b exp=00", bus.MEM_MemRead, bus.MEM_MemWrite); end
        step();
        nop();
        checks++; if (bus.WB_RegWrite !== 1'b0) begin failures++; $display("FAIL lu_wb_bubble got=%b exp=0", bus.WB_RegWrite); end
        step();
        nop();
        checks++; if (bus.WB_RegWrite !== 1'b1 || bus.WB_DestReg !== 5'd9) begin failures++; $display("FAIL lu_wb_add got=%b/%0d exp=1/9", bus.WB_RegWrite, bus.WB_DestReg); end
    endtask

    task automatic test_jal_jr();
        do_reset();
        drive(1'b1, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);               // JAL
        checks++; if (bus.ID_Jump !== 1'b1 || bus.Flush_IFID !== 1'b1 || bus.Stall !== 1'b0) begin failures++; $display("FAIL jal_id got=j%b f%b s%b exp=j1 f1 s0", bus.ID_Jump, bus.Flush_IFID, bus.Stall); end
        step();
        nop();
        checks++; if (bus.EX_RegDst !== 2'd2) begin failures++; $display("FAIL jal_ex_regdst got=%0d exp=2", bus.EX_RegDst); end
        step();
        nop();
        step();
        drive(1'b1, 6'd8, 6'd0, 5'd0, 5'd31, 5'd0, 1'b0);              // ADDI $31,$0,imm
        checks++; if (bus.WB_DestReg !== 5'd31 || bus.WB_MemtoReg !== 2'd2 || bus.WB_RegWrite !== 1'b1) begin failures++; $display("FAIL jal_wb got=d%0d m%0d w%b exp=d31 m2 w1", bus.WB_DestReg, bus.WB_MemtoReg, bus.WB_RegWrite); end
        step();
        drive(1'b1, 6'd0, 6'd8, 5'd31, 5'd0, 5'd0, 1'b0);              // JR $31
        checks++; if (bus.Stall !== 1'b1 || bus.Flush_IFID !== 1'b0) begin failures++; $display("FAIL jr_stall1 got=s%b f%b exp=s1 f0", bus.Stall, bus.Flush_IFID); end
        step();
        drive(1'b1, 6'd0, 6'd8, 5'd31, 5'd0, 5'd0, 1'b0);
        checks++; if (bus.Stall !== 1'b0 || bus.ID_JumpReg !== 1'b1 || bus.Flush_IFID !== 1'b1) begin failures++; $display("FAIL jr_go got=s%b jr%b f%b exp=s0 jr1 f1", bus.Stall, bus.ID_JumpReg, bus.Flush_IFID); end
        step();
        drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd31, 5'd0, 1'b0);             // LW $31
        step();
        drive(1'b1, 6'd0, 6'd8, 5'd31, 5'd0, 5'd0, 1'b0);              // JR $31 behind a load
        checks++; if (bus.Stall !== 1'b1) begin failures++; $display("FAIL jr_lw_stall1 got=%b exp=1", bus.Stall); end
        step();
        drive(1'b1, 6'd0, 6'd8, 5'd31, 5'd0, 5'd0, 1'b0);
        checks++; if (bus.Stall !== 1'b1 || bus.EX_ALUOp !== 4'd0 || bus.MEM_MemRead !== 1'b1) begin failures++; $display("FAIL jr_lw_stall2 got=s%b a%0d mr%b exp=s1 a0 mr1", bus.Stall, bus.EX_ALUOp, bus.MEM_MemRead); end
        step();
        drive(1'b1, 6'd0, 6'd8, 5'd31, 5'd0, 5'd0, 1'b0);
        checks++; if (bus.Stall !== 1'b0 || bus.ID_JumpReg !== 1'b1) begin failures++; $display("FAIL jr_lw_go got=s%b jr%b exp=s0 jr1", bus.Stall, bus.ID_JumpReg); end
        step();
        nop();
    endtask

    task automatic test_branch_squash();
        do_reset();
        drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd8, 5'd0, 1'b0);              // LW $8
        step();
        drive(1'b1, 6'd0, 6'd32, 5'd8, 5'd1, 5'd9, 1'b0);              // ADD dependent on $8
        checks++; if (bus.Stall !== 1'b1) begin failures++; $display("FAIL br_pending got=%b exp=1", bus.Stall); end
        bus.BranchTaken = 1'b1;
        #1;
        checks++; if (bus.Stall !== 1'b0 || bus.Flush_IFID !== 1'b1) begin failures++; $display("FAIL br_priority got=s%b f%b exp=s0 f1", bus.Stall, bus.Flush_IFID); end
        step();
        drive(1'b1, 6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1);               // JAL in ID during another taken branch
        checks++; if ({bus.EX_ALUOp, bus.EX_RegDst} !== 6'd0) begin failures++; $display("FAIL br_ex_bubble got=%h exp=0", {bus.EX_ALUOp, bus.EX_RegDst}); end
        checks++; if (bus.ID_Jump !== 1'b0 || bus.Flush_IFID !== 1'b1) begin failures++; $display("FAIL br_jal_gate got=j%b f%b exp=j0 f1", bus.ID_Jump, bus.Flush_IFID); end
        step();
        nop();
        checks++; if (bus.EX_RegDst !== 2'd0) begin failures++; $display("FAIL br_jal_squashed got=%0d exp=0", bus.EX_RegDst); end
    endtask

    task automatic test_illegal_reset();
        do_reset();
        drive(1'b1, 6'd63, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);              // unknown opcode
        step();
        drive(1'b1, 6'd0, 6'd1, 5'd1, 5'd2, 5'd3, 1'b0);               // unknown funct
        checks++; if ({bus.EX_ALUOp, bus.EX_RegDst} !== 6'd0) begin failures++; $display("FAIL ill_ex_bubble got=%h exp=0", {bus.EX_ALUOp, bus.EX_RegDst}); end
        step();
        nop();
        step();
        nop();
        checks++; if (bus.WB_Illegal !== 1'b1 || bus.WB_RegWrite !== 1'b0) begin failures++; $display("FAIL ill_op_wb got=i%b w%b exp=i1 w0", bus.WB_Illegal, bus.WB_RegWrite); end
        step();
        nop();
        checks++; if (bus.WB_Illegal !== 1'b1 || bus.WB_RegWrite !== 1'b0) begin failures++; $display("FAIL ill_fn_wb got=i%b w%b exp=i1 w0", bus.WB_Illegal, bus.WB_RegWrite); end
        step();
        nop();
        checks++; if (bus.WB_Illegal !== 1'b0) begin failures++; $display("FAIL ill_clear got=%b exp=0", bus.WB_Illegal); end
        // Fill the pipe, then reset with writes in every stage
        drive(1'b1, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        drive(1'b1, 6'd35, 6'd0, 5'd1, 5'd12, 5'd0, 1'b0);
        step();
        drive(1'b1, 6'd8, 6'd0, 5'd1, 5'd13, 5'd0, 1'b0);
        step();
        drive(1'b1, 6'd0, 6'd32, 5'd4, 5'd5, 5'd6, 1'b0);
        checks++; if (bus.WB_RegWrite !== 1'b1 || bus.MEM_MemRead !== 1'b1) begin failures++; $display("FAIL rst_prefill got=w%b mr%b exp=w1 mr1", bus.WB_RegWrite, bus.MEM_MemRead); end
        Reset = 1'b1;
        step();
        checks++; if (all_outs() !== 23'd0) begin failures++; $display("FAIL rst_midstream got=%h exp=0", all_outs()); end
        Reset = 1'b0;
        nop();
    endtask

    initial begin
        Reset = 1'b1;
        bus.InstrValid  = 1'b0;
        bus.Opcode      = 6'd0;
        bus.Function    = 6'd0;
        bus.Rs          = 5'd0;
        bus.Rt          = 5'd0;
        bus.Rd          = 5'd0;
        bus.BranchTaken = 1'b0;
        test_reset();
        test_decode();
        test_load_use();
        test_jal_jr();
        test_branch_squash();
        test_illegal_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
